asrv32_fsm_v2: RTL and testbench
================================

ASRV32_FSM_V2 -- requirements
Module: asrv32_fsm_v2

Interface
REQ-001 SHALL have parameter SKIP_MEM, default 1, meaning EXECUTE goes straight to WRITEBACK for opcodes other than LOAD/STORE/SYSTEM.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum MEMORYACCESS wait cycles before abort; legal range 1..255.
REQ-003 SHALL have parameter RETIRE_W, default 64, meaning the width of the retired-instruction counter.
REQ-004 SHALL have port i_clk  in  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports i_inst, i_pc, i_rs1_data, i_rs2_data, i_imm  in  32 each  fetched instruction, PC, rs1, rs2, immediate.
REQ-007 SHALL have port i_opcode  in  OPCODE_WIDTH  one-hot decoded opcode (RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE).
REQ-008 SHALL have ports i_inst_ack, i_mem_ack, i_stall, i_trap  in  1 each  fetch ack, data-memory ack, global hold, synchronous flush.
REQ-009 SHALL have ports o_inst_req, o_mem_req  out  1 each  fetch request, data-memory request.
REQ-010 SHALL have ports o_inst_q  out  32  and o_stage_q  out  3  registered instruction and current stage.
REQ-011 SHALL have ports o_op1, o_op2  out  32 each  ALU operands (combinational).
REQ-012 SHALL have ports o_alu_stage_en, o_memoryaccess_stage_en, o_writeback_stage_en, o_csr_stage_en, o_done_tick, o_timeout  out  1 each.
REQ-013 SHALL have port o_retire_cnt  out  RETIRE_W  count of retired instructions.

Function
REQ-014 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORYACCESS=3, WRITEBACK=4; encodings 5-7 SHALL go to FETCH next cycle.
REQ-015 Priority each cycle SHALL be: i_trap > i_stall > normal transition.
REQ-016 i_trap=1 SHALL force next state FETCH from any state, clear the wait counter, leave o_inst_q unchanged, and suppress o_done_tick.
REQ-017 i_stall=1 (no trap) SHALL hold stage, o_inst_q and wait counter; acks arriving that cycle SHALL be ignored.
REQ-018 FETCH: o_inst_req=1; on i_inst_ack, o_inst_q<=i_inst and go to DECODE; otherwise stay in FETCH, unbounded.
REQ-019 DECODE SHALL go to EXECUTE after one cycle.
REQ-020 EXECUTE: o_op1 = i_pc if JAL or AUIPC, else i_rs1_data; o_op2 = i_rs2_data if RTYPE or BRANCH, else i_imm; in all other states both SHALL be 0.
REQ-021 From EXECUTE, next SHALL be WRITEBACK when SKIP_MEM=1 and the opcode is not LOAD/STORE/SYSTEM; otherwise MEMORYACCESS.
REQ-022 MEMORYACCESS with LOAD or STORE: o_mem_req=1; i_mem_ack goes to WRITEBACK; each non-ack cycle increments an 8-bit wait counter.
REQ-023 When the wait counter equals MEM_TIMEOUT-1 with no ack, o_timeout SHALL pulse for one cycle, next state SHALL be FETCH, and the instruction SHALL NOT retire.
REQ-024 An ack arriving in the same cycle the timeout condition is reached SHALL win: go to WRITEBACK, no o_timeout.
REQ-025 MEMORYACCESS with any other opcode SHALL last exactly one cycle with o_mem_req=0; the wait counter SHALL clear on every MEMORYACCESS exit.
REQ-026 WRITEBACK SHALL go to FETCH; o_done_tick = (stage==WRITEBACK && next==FETCH && !i_trap && !i_stall).
REQ-027 o_retire_cnt SHALL increment on o_done_tick and wrap modulo 2^RETIRE_W.
REQ-028 Stage enables SHALL be decoded from o_stage_q: alu=EXECUTE, memoryaccess=MEMORYACCESS, writeback=WRITEBACK, csr=MEMORYACCESS.
REQ-029 Minimum latency SHALL be 4 cycles (skipped memory stage, immediate ack) and otherwise 5 cycles plus wait/stall cycles.

Reset
REQ-030 i_rst_n=0 SHALL asynchronously set stage=FETCH, o_inst_q=0, wait counter=0, o_retire_cnt=0, and o_timeout=0, regardless of mid-instruction state.
REQ-031 During reset, o_done_tick=0 and o_mem_req=0; o_inst_req=1 (FETCH) only after i_rst_n releases.

Verification
REQ-032 ADDI (x0,5) with SKIP_MEM=1 and immediate inst_ack -> stages 0,1,2,4,0; o_done_tick one cycle; o_retire_cnt=1; o_op2=5 in EXECUTE.
REQ-033 LW with i_mem_ack delayed 3 cycles -> o_mem_req high 4 cycles; WRITEBACK follows; o_retire_cnt=1.
REQ-034 SW with MEM_TIMEOUT=4 and no ack -> o_timeout pulse after 4 MEMORYACCESS cycles, then FETCH; o_retire_cnt unchanged; ack on 4th cycle -> no timeout.
REQ-035 i_stall for 2 cycles in EXECUTE, then i_trap in WRITEBACK -> stage held 3 cycles total; trap goes to FETCH, no done tick.
REQ-036 Assert i_rst_n=0 mid-MEMORYACCESS with o_retire_cnt preset near 2^RETIRE_W-1 -> immediate FETCH and all counters 0; separately, a retire at 2^RETIRE_W-1 wraps to 0.

Source files
------------

// File: rtl/asrv32_fsm_v2.sv
// Multi-cycle RV32 core control FSM: sequences FETCH/DECODE/EXECUTE/MEMORYACCESS/WRITEBACK,
// selects ALU operands, bounds data-memory waits and counts retired instructions.
module asrv32_fsm_v2 #(
  parameter int SKIP_MEM    = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 64,
  localparam int OPCODE_WIDTH = 11
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [31:0]             i_inst,
  input  logic [31:0]             i_pc,
  input  logic [31:0]             i_rs1_data,
  input  logic [31:0]             i_rs2_data,
  input  logic [31:0]             i_imm,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_inst_ack,
  input  logic                    i_mem_ack,
  input  logic                    i_stall,
  input  logic                    i_trap,
  output logic                    o_inst_req,
  output logic                    o_mem_req,
  output logic [31:0]             o_inst_q,
  output logic [2:0]              o_stage_q,
  output logic [31:0]             o_op1,
  output logic [31:0]             o_op2,
  output logic                    o_alu_stage_en,
  output logic                    o_memoryaccess_stage_en,
  output logic                    o_writeback_stage_en,
  output logic                    o_csr_stage_en,
  output logic                    o_done_tick,
  output logic                    o_timeout,
  output logic [RETIRE_W-1:0]     o_retire_cnt
);

  // One-hot opcode bit positions
  localparam int OP_RTYPE  = 0;
  localparam int OP_ITYPE  = 1;
  localparam int OP_LOAD   = 2;
  localparam int OP_STORE  = 3;
  localparam int OP_BRANCH = 4;
  localparam int OP_JAL    = 5;
  localparam int OP_JALR   = 6;
  localparam int OP_LUI    = 7;
  localparam int OP_AUIPC  = 8;
  localparam int OP_SYSTEM = 9;
  localparam int OP_FENCE  = 10;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    FETCH        = 3'd0,
    DECODE       = 3'd1,
    EXECUTE      = 3'd2,
    MEMORYACCESS = 3'd3,
    WRITEBACK    = 3'd4
  } stage_e;

  stage_e              stage_q, stage_d;
  logic [31:0]         inst_q, inst_d;
  logic [7:0]          wait_q, wait_d;
  logic                timeout_q, timeout_d;
  logic [RETIRE_W-1:0] retire_q;
  logic                done_tick;

  logic is_ldst, is_mem_path;
  assign is_ldst     = i_opcode[OP_LOAD] | i_opcode[OP_STORE];
  assign is_mem_path = is_ldst | i_opcode[OP_SYSTEM];

  logic unused_opcode_bits;
  assign unused_opcode_bits = ^{i_opcode[OP_ITYPE], i_opcode[OP_JALR],
                                i_opcode[OP_LUI], i_opcode[OP_FENCE]};

  always_comb begin
    stage_d   = stage_q;
    inst_d    = inst_q;
    wait_d    = wait_q;
    timeout_d = 1'b0;
    if (i_trap) begin
      stage_d = FETCH;
      wait_d  = '0;
    end else if (!i_stall) begin
      case (stage_q)
        FETCH: begin
          if (i_inst_ack) begin
            inst_d  = i_inst;
            stage_d = DECODE;
          end
        end
        DECODE:  stage_d = EXECUTE;
        EXECUTE: stage_d = ((SKIP_MEM != 0) && !is_mem_path) ? WRITEBACK : MEMORYACCESS;
        MEMORYACCESS: begin
          // An ack in the final wait cycle still completes the access
          if (!is_ldst || i_mem_ack) begin
            stage_d = WRITEBACK;
            wait_d  = '0;
          end else if (wait_q == WAIT_LAST) begin
            stage_d   = FETCH;
            wait_d    = '0;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        WRITEBACK: stage_d = FETCH;
        default:   stage_d = FETCH;
      endcase
    end
  end

  assign done_tick = (stage_q == WRITEBACK) && (stage_d == FETCH) && !i_trap && !i_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q   <= FETCH;
      inst_q    <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      stage_q   <= stage_d;
      inst_q    <= inst_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      if (done_tick) retire_q <= retire_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    o_op1 = '0;
    o_op2 = '0;
    if (stage_q == EXECUTE) begin
      o_op1 = (i_opcode[OP_JAL] | i_opcode[OP_AUIPC]) ? i_pc : i_rs1_data;
      o_op2 = (i_opcode[OP_RTYPE] | i_opcode[OP_BRANCH]) ? i_rs2_data : i_imm;
    end
  end

  // Fetch request is held off while reset is asserted
  assign o_inst_req              = (stage_q == FETCH) && i_rst_n;
  assign o_mem_req               = (stage_q == MEMORYACCESS) && is_ldst;
  assign o_inst_q                = inst_q;
  assign o_stage_q               = stage_q;
  assign o_alu_stage_en          = (stage_q == EXECUTE);
  assign o_memoryaccess_stage_en = (stage_q == MEMORYACCESS);
  assign o_writeback_stage_en    = (stage_q == WRITEBACK);
  assign o_csr_stage_en          = (stage_q == MEMORYACCESS);
  assign o_done_tick             = done_tick;
  assign o_timeout               = timeout_q;
  assign o_retire_cnt            = retire_q;

endmodule

// File: tb/tb_asrv32_fsm_v2.sv
// Directed bench for asrv32_fsm_v2 with a short timeout and a 3-bit retire counter.
module tb_asrv32_fsm_v2;

  localparam logic [10:0] OP_RTYPE  = 11'h001;
  localparam logic [10:0] OP_ITYPE  = 11'h002;
  localparam logic [10:0] OP_LOAD   = 11'h004;
  localparam logic [10:0] OP_STORE  = 11'h008;
  localparam logic [10:0] OP_AUIPC  = 11'h100;
  localparam logic [10:0] OP_SYSTEM = 11'h200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst, pc, rs1, rs2, imm;
  logic [10:0] opcode;
  logic        inst_ack, mem_ack, stall, trap;
  logic        inst_req, mem_req, alu_en, ma_en, wb_en, csr_en, done, timeout;
  logic [31:0] inst_q, op1, op2;
  logic [2:0]  stage;
  logic [2:0]  retire;

  int tests_run = 0;
  int tests_failed = 0;
  logic [2:0] exp_ret = 3'd0;

  asrv32_fsm_v2 #(.SKIP_MEM(1), .MEM_TIMEOUT(4), .RETIRE_W(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst(inst), .i_pc(pc), .i_rs1_data(rs1),
    .i_rs2_data(rs2), .i_imm(imm), .i_opcode(opcode), .i_inst_ack(inst_ack),
    .i_mem_ack(mem_ack), .i_stall(stall), .i_trap(trap), .o_inst_req(inst_req),
    .o_mem_req(mem_req), .o_inst_q(inst_q), .o_stage_q(stage), .o_op1(op1), .o_op2(op2),
    .o_alu_stage_en(alu_en), .o_memoryaccess_stage_en(ma_en),
    .o_writeback_stage_en(wb_en), .o_csr_stage_en(csr_en), .o_done_tick(done),
    .o_timeout(timeout), .o_retire_cnt(retire)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction with immediate ack; returns in DECODE.
  task automatic issue(input logic [10:0] opc, input logic [31:0] word);
    opcode = opc; inst = word; inst_ack = 1'b1;
    step();
    inst_ack = 1'b0;
  endtask

  task automatic run_addi();
    issue(OP_ITYPE, 32'h00100093);
    step(); step(); step();
    exp_ret = exp_ret + 3'd1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (stage !== 3'd0) begin tests_failed++; $display("FAIL reset_stage got %0d exp 0", stage); end
    tests_run++; if (inst_q !== 32'h0) begin tests_failed++; $display("FAIL reset_inst_q got %h exp 0", inst_q); end
    tests_run++; if (retire !== 3'd0) begin tests_failed++; $display("FAIL reset_retire got %0d exp 0", retire); end
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    tests_run++; if (inst_req !== 1'b0) begin tests_failed++; $display("FAIL reset_inst_req got %b exp 0", inst_req); end
    tests_run++; if (mem_req !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset_memreq_done got %b%b exp 00", mem_req, done); end
    rst_n = 1'b1;
    #1;
    tests_run++; if (inst_req !== 1'b1) begin tests_failed++; $display("FAIL release_inst_req got %b exp 1", inst_req); end
    step();
  endtask

  task automatic test_addi();
    opcode = OP_ITYPE; rs1 = 32'h0; imm = 32'd5; pc = 32'h100; rs2 = 32'h77;
    inst = 32'h00500093; inst_ack = 1'b1;
    step();
    inst_ack = 1'b0;
    tests_run++; if (stage !== 3'd1) begin tests_failed++; $display("FAIL addi_decode got %0d exp 1", stage); end
    tests_run++; if (inst_q !== 32'h00500093) begin tests_failed++; $display("FAIL addi_inst_q got %h exp 00500093", inst_q); end
    tests_run++; if (op2 !== 32'h0) begin tests_failed++; $display("FAIL addi_op2_decode got %h exp 0", op2); end
    step();
    tests_run++; if (stage !== 3'd2 || alu_en !== 1'b1) begin tests_failed++; $display("FAIL addi_execute got %0d/%b exp 2/1", stage, alu_en); end
    tests_run++; if (op2 !== 32'd5 || op1 !== 32'd0) begin tests_failed++; $display("FAIL addi_ops got %h,%h exp 0,5", op1, op2); end
    step();
    tests_run++; if (stage !== 3'd4 || wb_en !== 1'b1) begin tests_failed++; $display("FAIL addi_wb got %0d/%b exp 4/1", stage, wb_en); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL addi_done got %b exp 1", done); end
    step();
    tests_run++; if (stage !== 3'd0 || done !== 1'b0) begin tests_failed++; $display("FAIL addi_back_fetch got %0d/%b exp 0/0", stage, done); end
    tests_run++; if (retire !== 3'd1) begin tests_failed++; $display("FAIL addi_retire got %0d exp 1", retire); end
    exp_ret = 3'd1;
  endtask

  task automatic test_operands();
    pc = 32'h1000; imm = 32'h2000; rs1 = 32'hAAAA; rs2 = 32'hBBBB;
    issue(OP_AUIPC, 32'h00002097);
    step();
    tests_run++; if (op1 !== 32'h1000 || op2 !== 32'h2000) begin tests_failed++; $display("FAIL auipc_ops got %h,%h exp 1000,2000", op1, op2); end
    step();
    tests_run++; if (stage !== 3'd4) begin tests_failed++; $display("FAIL auipc_skip_mem got %0d exp 4", stage); end
    step(); exp_ret = exp_ret + 3'd1;
    issue(OP_RTYPE, 32'h002081b3);
    step();
    tests_run++; if (op1 !== 32'hAAAA || op2 !== 32'hBBBB) begin tests_failed++; $display("FAIL rtype_ops got %h,%h exp aaaa,bbbb", op1, op2); end
    step(); step(); exp_ret = exp_ret + 3'd1;
    tests_run++; if (retire !== 3'd3) begin tests_failed++; $display("FAIL operands_retire got %0d exp 3", retire); end
  endtask

  task automatic test_lw_delayed();
    int mreq_cnt;
    mreq_cnt = 0;
    issue(OP_LOAD, 32'h0000a103);
    step(); step();
    // ack lands in the 4th wait cycle, which is also the timeout cycle: ack wins
    for (int k = 0; k < 4; k++) begin
      tests_run++; if (stage !== 3'd3 || ma_en !== 1'b1) begin tests_failed++; $display("FAIL lw_in_ma cyc%0d got %0d exp 3", k, stage); end
      if (mem_req === 1'b1) mreq_cnt++;
      if (k == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    tests_run++; if (mreq_cnt != 4) begin tests_failed++; $display("FAIL lw_memreq_cycles got %0d exp 4", mreq_cnt); end
    tests_run++; if (stage !== 3'd4 || timeout !== 1'b0) begin tests_failed++; $display("FAIL lw_ack_wins got %0d/%b exp 4/0", stage, timeout); end
    step(); exp_ret = exp_ret + 3'd1;
    tests_run++; if (retire !== 3'd4) begin tests_failed++; $display("FAIL lw_retire got %0d exp 4", retire); end
  endtask

  task automatic test_sw_timeout();
    issue(OP_STORE, 32'h0020a023);
    step(); step();
    for (int k = 0; k < 4; k++) begin
      tests_run++; if (stage !== 3'd3 || mem_req !== 1'b1) begin tests_failed++; $display("FAIL sw_wait cyc%0d got %0d/%b exp 3/1", k, stage, mem_req); end
      step();
    end
    tests_run++; if (stage !== 3'd0 || timeout !== 1'b1) begin tests_failed++; $display("FAIL sw_timeout got %0d/%b exp 0/1", stage, timeout); end
    tests_run++; if (retire !== 3'd4) begin tests_failed++; $display("FAIL sw_no_retire got %0d exp 4", retire); end
    step();
    tests_run++; if (timeout !== 1'b0 || stage !== 3'd0) begin tests_failed++; $display("FAIL sw_timeout_pulse got %b/%0d exp 0/0", timeout, stage); end
  endtask

  task automatic test_system();
    issue(OP_SYSTEM, 32'h00000073);
    step(); step();
    tests_run++; if (stage !== 3'd3 || mem_req !== 1'b0 || csr_en !== 1'b1) begin tests_failed++; $display("FAIL system_ma got %0d/%b/%b exp 3/0/1", stage, mem_req, csr_en); end
    step();
    tests_run++; if (stage !== 3'd4) begin tests_failed++; $display("FAIL system_one_cycle got %0d exp 4", stage); end
    step(); exp_ret = exp_ret + 3'd1;
    tests_run++; if (retire !== 3'd5) begin tests_failed++; $display("FAIL system_retire got %0d exp 5", retire); end
  endtask

  task automatic test_stall_trap();
    opcode = OP_ITYPE; stall = 1'b1; inst_ack = 1'b1; inst = 32'hDEADBEEF;
    step();
    tests_run++; if (stage !== 3'd0 || inst_q !== 32'h00000073) begin tests_failed++; $display("FAIL stall_ignores_ack got %0d/%h exp 0/00000073", stage, inst_q); end
    stall = 1'b0; inst = 32'h00a00113;
    step(); inst_ack = 1'b0;
    step();
    stall = 1'b1;
    step(); step();
    tests_run++; if (stage !== 3'd2) begin tests_failed++; $display("FAIL stall_hold got %0d exp 2", stage); end
    stall = 1'b0;
    step();
    tests_run++; if (stage !== 3'd4) begin tests_failed++; $display("FAIL stall_release got %0d exp 4", stage); end
    trap = 1'b1;
    #1;
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL trap_done got %b exp 0", done); end
    step(); trap = 1'b0;
    tests_run++; if (stage !== 3'd0 || inst_q !== 32'h00a00113) begin tests_failed++; $display("FAIL trap_fetch got %0d/%h exp 0/00a00113", stage, inst_q); end
    tests_run++; if (retire !== 3'd5) begin tests_failed++; $display("FAIL trap_no_retire got %0d exp 5", retire); end
    // Trap partway through a wait must restart the timeout window
    issue(OP_STORE, 32'h0020a023);
    step(); step(); step(); step();
    trap = 1'b1; step(); trap = 1'b0;
    issue(OP_STORE, 32'h0020a023);
    step(); step(); step(); step(); step();
    tests_run++; if (stage !== 3'd3) begin tests_failed++; $display("FAIL trap_clears_wait got %0d exp 3", stage); end
    step();
    tests_run++; if (timeout !== 1'b1) begin tests_failed++; $display("FAIL trap_then_timeout got %b exp 1", timeout); end
  endtask

  task automatic test_back_to_back();
    int exp_seq [8] = '{1, 2, 4, 0, 1, 2, 4, 0};
    int dones;
    dones = 0;
    opcode = OP_ITYPE; inst = 32'h00100093; inst_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) dones++;
      step();
      tests_run++; if (stage !== 3'(exp_seq[i])) begin tests_failed++; $display("FAIL b2b_seq cyc%0d got %0d exp %0d", i, stage, exp_seq[i]); end
    end
    inst_ack = 1'b0;
    exp_ret = exp_ret + 3'd2;
    tests_run++; if (dones != 2) begin tests_failed++; $display("FAIL b2b_done_count got %0d exp 2", dones); end
    tests_run++; if (retire !== 3'd7) begin tests_failed++; $display("FAIL b2b_retire got %0d exp 7", retire); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8 && exp_ret != 3'd7; i++) run_addi();
    tests_run++; if (retire !== 3'd7) begin tests_failed++; $display("FAIL wrap_pre got %0d exp 7", retire); end
    run_addi();
    tests_run++; if (retire !== 3'd0) begin tests_failed++; $display("FAIL wrap_to_zero got %0d exp 0", retire); end
  endtask

  task automatic test_reset_mid_ma();
    for (int i = 0; i < 8 && exp_ret != 3'd6; i++) run_addi();
    tests_run++; if (retire !== 3'd6) begin tests_failed++; $display("FAIL rstmid_pre got %0d exp 6", retire); end
    issue(OP_LOAD, 32'h0000a103);
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (stage !== 3'd0 || retire !== 3'd0) begin tests_failed++; $display("FAIL rstmid_async got %0d/%0d exp 0/0", stage, retire); end
    tests_run++; if (inst_q !== 32'h0 || mem_req !== 1'b0 || inst_req !== 1'b0) begin tests_failed++; $display("FAIL rstmid_outputs got %h/%b/%b exp 0/0/0", inst_q, mem_req, inst_req); end
    step();
    rst_n = 1'b1; exp_ret = 3'd0;
    // Wait counter must restart from zero after reset
    issue(OP_STORE, 32'h0020a023);
    step(); step(); step(); step(); step();
    tests_run++; if (stage !== 3'd3 || timeout !== 1'b0) begin tests_failed++; $display("FAIL rstmid_wait_cleared got %0d/%b exp 3/0", stage, timeout); end
    step();
    tests_run++; if (timeout !== 1'b1 || retire !== 3'd0) begin tests_failed++; $display("FAIL rstmid_timeout got %b/%0d exp 1/0", timeout, retire); end
  endtask

  initial begin
    rst_n = 1'b0; inst = '0; pc = '0; rs1 = '0; rs2 = '0; imm = '0; opcode = OP_ITYPE;
    inst_ack = 1'b0; mem_ack = 1'b0; stall = 1'b0; trap = 1'b0;
    test_reset();
    test_addi();
    test_operands();
    test_lw_delayed();
    test_sw_timeout();
    test_system();
    test_stall_trap();
    test_back_to_back();
    test_wrap();
    test_reset_mid_ma();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
